imm_gen_stage: RTL

Pipelined, parametrised immediate-generation stage for the RV32I/RV64I decode path. It accepts a fetched instruction with a valid/ready handshake and produces the sign- or zero-extended immediate, XLEN bits wide, one cycle later. A two-entry skid buffer gives full throughput under backpressure. An optional auto-decode mode derives the immediate format from the opcode, so the decoder does not have to supply it.

---
 rtl/imm_gen_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage for the RV32I/RV64I decode path: decodes the
// immediate from an instruction word and holds it in a main/skid register pair.
module imm_gen_stage #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int AUTO_DECODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] SEL_I     = 3'b000;
    localparam logic [2:0] SEL_S     = 3'b001;
    localparam logic [2:0] SEL_B     = 3'b010;
    localparam logic [2:0] SEL_J     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_Z     = 3'b101;
    localparam logic [2:0] SEL_SHAMT = 3'b110;
    localparam logic [2:0] SEL_RSV   = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [2:0]       fmt;
    logic [31:0]      raw32;
    logic             raw_sext;
    logic             new_illegal;
    logic [XLEN-1:0]  new_imm;
    logic             xfer_in;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic             main_ill_q, main_ill_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    // Format select: either supplied by the decoder or derived from the opcode.
    always_comb begin
        fmt = in_sel;
        if (AUTO_DECODE != 0) begin
            case (in_instr[6:0])
                OP_LOAD, OP_JALR: fmt = SEL_I;
                OP_IMM: begin
                    if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                        fmt = SEL_SHAMT;
                    else
                        fmt = SEL_I;
                end
                OP_SYSTEM:        fmt = in_instr[14] ? SEL_Z : SEL_I;
                OP_STORE:         fmt = SEL_S;
                OP_BRANCH:        fmt = SEL_B;
                OP_JAL:           fmt = SEL_J;
                OP_LUI, OP_AUIPC: fmt = SEL_U;
                default:          fmt = SEL_RSV;
            endcase
        end
    end

    // Build a 32-bit immediate first, then widen to XLEN by sign or zero fill.
    always_comb begin
        raw32       = '0;
        raw_sext    = 1'b1;
        new_illegal = 1'b0;
        case (fmt)
            SEL_I: raw32 = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_S: raw32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B: raw32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_J: raw32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            SEL_U: raw32 = {in_instr[31:12], 12'b0};
            SEL_Z: begin
                raw32    = {27'b0, in_instr[19:15]};
                raw_sext = 1'b0;
            end
            SEL_SHAMT: begin
                raw_sext = 1'b0;
                if (XLEN == 64)
                    raw32 = {26'b0, in_instr[25:20]};
                else
                    raw32 = {27'b0, in_instr[24:20]};
            end
            default: begin
                raw32       = '0;
                raw_sext    = 1'b0;
                new_illegal = 1'b1;
            end
        endcase
        if (raw_sext)
            new_imm = XLEN'(signed'(raw32));
        else
            new_imm = XLEN'(raw32);
    end

    assign in_ready = !skid_valid_q;
    assign xfer_in  = in_valid && in_ready;

    // Main only holds while stalled; otherwise it refills from skid first, then input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_ill_d   = main_ill_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_ready) begin
            if (xfer_in) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = new_imm;
                skid_ill_d   = new_illegal;
                skid_tag_d   = in_tag;
            end
        end else if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_ill_d   = skid_ill_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
        end else if (xfer_in) begin
            main_valid_d = 1'b1;
            main_imm_d   = new_imm;
            main_ill_d   = new_illegal;
            main_tag_d   = in_tag;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_ill_q   <= 1'b0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_ill_q   <= main_ill_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;

endmodule
